// File: rtl/mux_rr_sched_if.sv
// Handshake bundle between the four requesters, the shared 4:1 mux and the sink.
// The slave modport is the scheduler's side. The master modport is the
// requester/sink side.
interface mux_rr_sched_if #(
  parameter int DW = 1
);
  logic [3:0]      req;
  logic [4*DW-1:0] din;
  logic [3:0]      ack;
  logic [1:0]      sel;
  logic [DW-1:0]   y;
  logic            y_valid;
  logic            y_ready;
  logic            busy;

  modport slave (
    input  req, din, y_ready,
    output ack, sel, y, y_valid, busy
  );

  modport master (
    output req, din, y_ready,
    input  ack, sel, y, y_valid, busy
  );
endinterface

// File: rtl/mux_rr_sched.sv
// Round-robin scheduler that shares one 4:1 mux among four requesters.
// It registers the winning word and offers it downstream on a valid/ready
// handshake. When the sink consumes a word, it sends a one-cycle ack back to
// the requester that supplied it.
//
// Build option: define MUX_FIXED_PRIO_EN to get fixed priority (0 > 1 > 2 > 3).
// In that mode the last-grant pointer is not built and PTR_INIT is ignored.
//
// state | meaning
// IDLE  | no word held, y_valid=0, waiting for any req
// GRANT | word from requester sel held in y, y_valid=1, waiting for y_ready
module mux_rr_sched #(
  parameter int         DW       = 1,
  parameter logic [1:0] PTR_INIT = 2'd3
) (
  input  logic          clk,
  input  logic          rst,
  mux_rr_sched_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [1:0]    sel_q, sel_d;
  logic [DW-1:0] y_q, y_d;
  logic          y_valid_q, y_valid_d;

  logic          hs;
  logic [3:0]    sel_onehot;
  logic [3:0]    elig;
  logic [1:0]    win;
  logic [DW-1:0] din_win;

`ifdef MUX_FIXED_PRIO_EN
  // Lowest set index wins; the scan runs high-to-low so the last hit is the lowest.
  function automatic logic [1:0] pick(input logic [3:0] mask);
    logic [1:0] w;
    w = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (mask[k]) w = 2'(k);
    end
    return w;
  endfunction
`else
  logic [1:0] last_q, last_d;
  logic [1:0] ptr;

  // First set bit of mask scanning ptr+1, ptr+2, ... modulo 4.
  function automatic logic [1:0] pick(input logic [3:0] mask, input logic [1:0] p);
    logic [1:0] idx;
    logic [1:0] w;
    logic       found;
    w     = 2'd0;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = p + 2'(k);
      if (!found && mask[idx]) begin
        w     = idx;
        found = 1'b1;
      end
    end
    return w;
  endfunction
`endif

  assign hs         = y_valid_q & bus.y_ready;
  assign sel_onehot = 4'b0001 << sel_q;

  // In the ack cycle the requester being acked is masked, so it can't be granted twice in a row.
  assign elig = (state_q == GRANT) ? (bus.req & ~sel_onehot) : bus.req;

`ifdef MUX_FIXED_PRIO_EN
  assign win = pick(elig);
`else
  // At a handshake edge, last becomes sel, so the search starts just after sel.
  assign ptr = (state_q == GRANT) ? sel_q : last_q;
  assign win = pick(elig, ptr);
`endif

  assign din_win = bus.din[int'(win)*DW +: DW];

  // State register and the registered datapath (select, data word, valid, pointer).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      sel_q     <= 2'd0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
`ifndef MUX_FIXED_PRIO_EN
      last_q    <= PTR_INIT;
`endif
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
`ifndef MUX_FIXED_PRIO_EN
      last_q    <= last_d;
`endif
    end
  end

  // Next-state logic: grant from IDLE, then regrant back-to-back or release on each handshake.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    y_d       = y_q;
    y_valid_d = y_valid_q;
`ifndef MUX_FIXED_PRIO_EN
    last_d    = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          state_d   = GRANT;
          sel_d     = win;
          y_d       = din_win;
          y_valid_d = 1'b1;
        end
      end
      GRANT: begin
        if (hs) begin
`ifndef MUX_FIXED_PRIO_EN
          last_d = sel_q;
`endif
          if (|elig) begin
            sel_d = win;
            y_d   = din_win;
          end else begin
            y_valid_d = 1'b0;
            state_d   = IDLE;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        y_valid_d = 1'b0;
      end
    endcase
  end

  // Outputs: ack is a one-hot pulse only in the handshake cycle; busy follows the state.
  always_comb begin
    bus.ack  = 4'b0000;
    bus.busy = (state_q == GRANT);
    if (hs) bus.ack = sel_onehot;
  end

  assign bus.sel     = sel_q;
  assign bus.y       = y_q;
  assign bus.y_valid = y_valid_q;

endmodule
